ln_vec_packer: RTL

Serial-to-parallel front end for the layer-norm engine. It accepts a stream of Q8.8 elements over a valid/ready handshake and packs them into the 256-bit flat vector the LN mean/normalise datapath consumes (lane i = bits [i*16 +: 16]). It also emits the element count and the running sum, so the downstream mean stage can skip its adder tree. Double-buffered: collection continues while the previous vector waits for the consumer.

---
 rtl/ln_pkg.sv | 18 +
 rtl/ln_lane_mask.sv | 19 +
 rtl/ln_vec_packer.sv | 112 +++++++++++
 3 files changed

// File: rtl/ln_pkg.sv
// Shared layer-norm constants: Q8.8 element format, vector length and derived widths.
// Also holds the lane-slice helper used wherever a flat vector is indexed by lane.
package ln_pkg;

    localparam int unsigned LN_DATA_W  = 16;
    localparam int unsigned LN_FRAC_W  = 8;
    localparam int unsigned LN_VEC_LEN = 16;
    localparam int unsigned LN_CNT_W   = $clog2(LN_VEC_LEN) + 1;
    localparam int unsigned LN_SUM_W   = LN_DATA_W + $clog2(LN_VEC_LEN);

    typedef logic [LN_DATA_W-1:0] ln_q88_t;

    function automatic int unsigned ln_lane_lsb(input int unsigned index,
                                                input int unsigned data_w);
        return index * data_w;
    endfunction

endpackage

// File: rtl/ln_lane_mask.sv
// Lane enable mask: lane i is enabled when i < i_count.
module ln_lane_mask
    import ln_pkg::*;
#(
    parameter int unsigned VEC_LEN = LN_VEC_LEN,
    parameter int unsigned CNT_W   = LN_CNT_W
) (
    input  logic [CNT_W-1:0]   i_count,
    output logic [VEC_LEN-1:0] o_en
);

    always_comb begin
        o_en = '0;
        for (int unsigned i = 0; i < VEC_LEN; i++) begin
            o_en[i] = (CNT_W'(i) < i_count);
        end
    end

endmodule

// File: rtl/ln_vec_packer.sv
// Serial-to-parallel packer for the LN engine: collects Q8.8 elements into a flat vector
// with lane count and running sum; one collect buffer plus one output register.
module ln_vec_packer
    import ln_pkg::*;
#(
    parameter int unsigned DATA_W  = LN_DATA_W,
    parameter int unsigned VEC_LEN = LN_VEC_LEN,
    parameter int unsigned CNT_W   = LN_CNT_W,
    parameter int unsigned SUM_W   = LN_SUM_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_W*VEC_LEN-1:0]   x_in_flat,
    output logic [CNT_W-1:0]            m_count,
    output logic [SUM_W-1:0]            m_sum
);

    localparam int unsigned IDX_W = $clog2(VEC_LEN);

    logic [IDX_W-1:0]          r_idx;
    logic                      r_col_full;
    logic [SUM_W-1:0]          r_col_sum;
    logic [CNT_W-1:0]          r_col_cnt;
    logic [DATA_W-1:0]         r_lanes [VEC_LEN];

    logic                      w_out_free;
    logic                      w_xfer;
    logic                      w_accept;
    logic                      w_close;
    logic [SUM_W-1:0]          w_sum_base;
    logic [VEC_LEN-1:0]        w_lane_en;
    logic [DATA_W*VEC_LEN-1:0] w_packed;

    assign w_out_free = !m_valid || m_ready;
    assign w_xfer     = r_col_full && w_out_free;
    assign s_ready    = !r_col_full || w_out_free;
    assign w_accept   = s_valid && s_ready;
    assign w_close    = w_accept && ((r_idx == IDX_W'(VEC_LEN - 1)) || s_last);

    // Accepting while full only happens on a transfer edge, so the sum restarts from this element.
    assign w_sum_base = r_col_full ? '0 : r_col_sum;

    ln_lane_mask #(
        .VEC_LEN (VEC_LEN),
        .CNT_W   (CNT_W)
    ) u_lane_mask (
        .i_count (r_col_cnt),
        .o_en    (w_lane_en)
    );

    always_comb begin
        w_packed = '0;
        for (int unsigned i = 0; i < VEC_LEN; i++) begin
            if (w_lane_en[i]) begin
                w_packed[ln_lane_lsb(i, DATA_W) +: DATA_W] = r_lanes[i];
            end
        end
    end

    // Stale lanes are never exposed: the mask zeroes everything at or above the count.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lanes[r_idx] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx      <= '0;
            r_col_full <= 1'b0;
            r_col_sum  <= '0;
            r_col_cnt  <= '0;
            m_valid    <= 1'b0;
            x_in_flat  <= '0;
            m_count    <= '0;
            m_sum      <= '0;
        end else begin
            if (w_accept) begin
                r_col_sum <= w_sum_base + SUM_W'(s_data);
                if (w_close) begin
                    r_col_full <= 1'b1;
                    r_col_cnt  <= CNT_W'(r_idx) + CNT_W'(1);
                    r_idx      <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end

            if (w_xfer) begin
                x_in_flat <= w_packed;
                m_count   <= r_col_cnt;
                m_sum     <= r_col_sum;
                m_valid   <= 1'b1;
                if (!w_close) begin
                    r_col_full <= 1'b0;
                end
                if (!w_accept) begin
                    r_col_sum <= '0;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
